matrix_generate_kxk: RTL and testbench

- Parametrised successor of the 3x3 window generator in the grayscale filter chain.
- Accepts a raster pixel stream with a per-pixel write strobe. Gaps between strobes are allowed.
- Emits one KSIZE x KSIZE neighbourhood per accepted pixel, with frame/line position flags and selectable border handling.
- Sits between the gray conversion stage and the Sobel/median/Gaussian kernels, so one block serves 3x3 and 5x5 filters.

---
 rtl/matrix_generate_kxk.sv | 126 ++++++++++++
 tb/tb_matrix_generate_kxk.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_generate_kxk.sv
// rtl/matrix_generate_kxk.sv - causal KSIZE x KSIZE window generator over a raster pixel stream
// Line buffers feed the right tap column; out-of-frame taps are optionally masked to zero.
module matrix_generate_kxk #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int KSIZE       = 3,
    parameter int BORDER_MODE = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pix_wr_en,
    input  logic                            pix_sof,
    input  logic [DATA_W-1:0]               pix_in,
    output logic                            win_wr_en,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   win_data,
    output logic                            win_sof,
    output logic                            win_eol,
    output logic                            win_eof,
    output logic                            win_border
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NB = KSIZE - 1;

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;
    logic              at_sof, at_eol, at_eof, border_d;
    logic [KSIZE-1:0]  row_ok, col_ok;

    logic [DATA_W-1:0] lbuf_mem [NB][IMG_W];
    logic [DATA_W-1:0] lbuf_rd  [NB];
    logic [DATA_W-1:0] new_col  [KSIZE];
    logic [DATA_W-1:0] tap_q    [KSIZE][KSIZE];
    logic [DATA_W-1:0] tap_d    [KSIZE][KSIZE];
    logic [KSIZE*KSIZE*DATA_W-1:0] win_data_d;

    // A strobed sof overrides the counters so the pixel is treated as (0,0).
    always_comb begin
        cur_col = pix_sof ? '0 : col_q;
        cur_row = pix_sof ? '0 : row_q;
        at_sof  = (cur_col == '0) && (cur_row == '0);
        at_eol  = (cur_col == CW'(IMG_W - 1));
        at_eof  = at_eol && (cur_row == RW'(IMG_H - 1));
        col_d   = at_eol ? '0 : cur_col + CW'(1);
        if (at_eol)
            row_d = at_eof ? '0 : cur_row + RW'(1);
        else
            row_d = cur_row;
    end

    always_comb begin
        for (int k = 0; k < NB; k++)
            lbuf_rd[k] = lbuf_mem[k][cur_col];
    end

    // Top row of the new column is the oldest line.
    always_comb begin
        for (int r = 0; r < KSIZE - 1; r++)
            new_col[r] = lbuf_rd[KSIZE-2-r];
        new_col[KSIZE-1] = pix_in;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++)
                tap_d[r][c] = tap_q[r][c+1];
            tap_d[r][KSIZE-1] = new_col[r];
        end
    end

    always_comb begin
        row_ok = '1;
        col_ok = '1;
        for (int i = 0; i < KSIZE - 1; i++) begin
            row_ok[i] = (cur_row >= RW'(KSIZE - 1 - i));
            col_ok[i] = (cur_col >= CW'(KSIZE - 1 - i));
        end
        border_d   = ~(&row_ok) | ~(&col_ok);
        win_data_d = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (BORDER_MODE != 0 && !(row_ok[r] && col_ok[c]))
                    win_data_d[(r*KSIZE+c)*DATA_W +: DATA_W] = '0;
                else
                    win_data_d[(r*KSIZE+c)*DATA_W +: DATA_W] = tap_d[r][c];
            end
        end
    end

    // Line buffers are plain RAM: read-before-write, cascaded buffer to buffer.
    always_ff @(posedge clk) begin
        if (pix_wr_en) begin
            lbuf_mem[0][cur_col] <= pix_in;
            for (int k = 1; k < NB; k++)
                lbuf_mem[k][cur_col] <= lbuf_rd[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_wr_en  <= 1'b0;
            win_data   <= '0;
            win_sof    <= 1'b0;
            win_eol    <= 1'b0;
            win_eof    <= 1'b0;
            win_border <= 1'b0;
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    tap_q[r][c] <= '0;
        end else begin
            win_wr_en <= pix_wr_en;
            if (pix_wr_en) begin
                col_q      <= col_d;
                row_q      <= row_d;
                tap_q      <= tap_d;
                win_data   <= win_data_d;
                win_sof    <= at_sof;
                win_eol    <= at_eol;
                win_eof    <= at_eof;
                win_border <= border_d;
            end
        end
    end

endmodule

// File: tb/tb_matrix_generate_kxk.sv
// tb/tb_matrix_generate_kxk.sv - scoreboard bench for the 3x3 and 5x5 window generator
module tb_matrix_generate_kxk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, a_wr, a_sof, a_wen, a_sofo, a_eol, a_eof, a_border;
    logic [7:0]  a_pix;
    logic [71:0] a_data;
    logic        rst_b, b_wr, b_sof, b_wen, b_sofo, b_eol, b_eof, b_border;
    logic [7:0]  b_pix;
    logic [199:0] b_data;

    matrix_generate_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .KSIZE(3), .BORDER_MODE(1)) dut_a (
        .clk(clk), .rst(rst_a), .pix_wr_en(a_wr), .pix_sof(a_sof), .pix_in(a_pix),
        .win_wr_en(a_wen), .win_data(a_data), .win_sof(a_sofo), .win_eol(a_eol),
        .win_eof(a_eof), .win_border(a_border));

    matrix_generate_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .KSIZE(5), .BORDER_MODE(1)) dut_b (
        .clk(clk), .rst(rst_b), .pix_wr_en(b_wr), .pix_sof(b_sof), .pix_in(b_pix),
        .win_wr_en(b_wen), .win_data(b_data), .win_sof(b_sofo), .win_eol(b_eol),
        .win_eof(b_eof), .win_border(b_border));

    typedef struct {
        logic [199:0] data;
        logic [3:0]   fl;
        int           tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int img [2][8][8];
    int mr [2];
    int mc [2];

    task automatic chk(input string nm, input int tag, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, exp);
        end
    endtask

    // Expected window from a frame-coordinate image, optionally replaced by a hand-written vector.
    task automatic send(input int d, input int val, input bit sof, input bit gap,
                        input bit hand, input logic [199:0] hd, input logic [3:0] hf);
        exp_t e;
        int k, h, v;
        k = (d == 0) ? 3 : 5;
        h = (d == 0) ? 4 : 8;
        if (sof) begin
            mr[d] = 0;
            mc[d] = 0;
        end
        img[d][mr[d]][mc[d]] = val;
        e.data = '0;
        for (int rr = 0; rr < k; rr++)
            for (int cc = 0; cc < k; cc++) begin
                if (mr[d] >= k-1-rr && mc[d] >= k-1-cc)
                    v = img[d][mr[d]-k+1+rr][mc[d]-k+1+cc];
                else
                    v = 0;
                e.data[(rr*k+cc)*8 +: 8] = v[7:0];
            end
        e.fl  = {(mr[d] == 0 && mc[d] == 0), (mc[d] == 7), (mc[d] == 7 && mr[d] == h-1),
                 (mr[d] < k-1 || mc[d] < k-1)};
        e.tag = val;
        if (hand) begin
            e.data = hd;
            e.fl   = hf;
        end
        if (d == 0) begin
            qa.push_back(e);
            a_wr = 1'b1; a_sof = sof; a_pix = val[7:0];
        end else begin
            qb.push_back(e);
            b_wr = 1'b1; b_sof = sof; b_pix = val[7:0];
        end
        @(negedge clk);
        if (gap) begin
            a_wr = 1'b0; a_sof = 1'b0; b_wr = 1'b0; b_sof = 1'b0;
            @(negedge clk);
        end
        if (mc[d] == 7) begin
            mc[d] = 0;
            mr[d] = (mr[d] == h-1) ? 0 : mr[d] + 1;
        end else begin
            mc[d] = mc[d] + 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++)
            @(negedge clk);
        chk("queue_drain", 0, 200'(qa.size() + qb.size()), 200'd0);
    endtask

    // Monitor: latency, hold-when-idle and scoreboard compare for both instances.
    initial begin
        logic pa, pb;
        logic [71:0]  last_a;
        logic [199:0] last_b;
        exp_t e;
        last_a = '0;
        last_b = '0;
        forever begin
            @(posedge clk);
            pa = a_wr;
            pb = b_wr;
            #1;
            if (!rst_a) begin
                chk("latency_a", 0, {199'd0, a_wen}, {199'd0, pa});
                if (a_wen) begin
                    if (qa.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_window_a actual=1 required=0");
                    end else begin
                        e = qa.pop_front();
                        chk("win_data_a", e.tag, {128'd0, a_data}, e.data);
                        chk("flags_a", e.tag, {196'd0, a_sofo, a_eol, a_eof, a_border}, {196'd0, e.fl});
                    end
                end else if (!pa) begin
                    chk("hold_a", 0, {128'd0, a_data}, {128'd0, last_a});
                end
            end
            last_a = a_data;
            if (!rst_b) begin
                chk("latency_b", 0, {199'd0, b_wen}, {199'd0, pb});
                if (b_wen) begin
                    if (qb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_window_b actual=1 required=0");
                    end else begin
                        e = qb.pop_front();
                        chk("win_data_b", e.tag, b_data, e.data);
                        chk("flags_b", e.tag, {196'd0, b_sofo, b_eol, b_eof, b_border}, {196'd0, e.fl});
                    end
                end else if (!pb) begin
                    chk("hold_b", 0, b_data, last_b);
                end
            end
            last_b = b_data;
        end
    end

    initial begin
        logic [199:0] hd;
        logic [3:0]   hf;
        bit           hand;
        rst_a = 1'b1; rst_b = 1'b1;
        a_wr = 1'b0; a_sof = 1'b0; a_pix = '0;
        b_wr = 1'b0; b_sof = 1'b0; b_pix = '0;
        mr[0] = 0; mc[0] = 0; mr[1] = 0; mc[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    img[d][r][c] = 0;
        repeat (3) @(negedge clk);
        chk("reset_out_a", 0, {124'd0, a_data, a_wen, a_sofo, a_eol, a_eof}, 200'd0);
        chk("reset_out_b", 0, {b_data}, 200'd0);
        chk("reset_flags_b", 0, {196'd0, b_wen, b_sofo, b_eol, b_border}, 200'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // 3x3: frame of 1..32, wrap into a second frame, mid-line resync at value 45.
        for (int v = 1; v <= 60; v++) begin
            hand = 1'b1;
            hd   = '0;
            case (v)
                1:  begin hd[71:0] = {8'd1, 64'd0}; hf = 4'b1001; end
                8:  begin hd[71:0] = {8'd8, 8'd7, 8'd6, 48'd0}; hf = 4'b0101; end
                10: begin hd[71:0] = {8'd10, 8'd9, 8'd0, 8'd2, 8'd1, 8'd0, 24'd0}; hf = 4'b0001; end
                19: begin hd[71:0] = {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9, 8'd3, 8'd2, 8'd1}; hf = 4'b0000; end
                32: begin hd[71:0] = {8'd32, 8'd31, 8'd30, 8'd24, 8'd23, 8'd22, 8'd16, 8'd15, 8'd14}; hf = 4'b0110; end
                33: begin hd[71:0] = {8'd33, 64'd0}; hf = 4'b1001; end
                45: begin hd[71:0] = {8'd45, 64'd0}; hf = 4'b1001; end
                default: begin hand = 1'b0; hf = 4'b0000; end
            endcase
            send(0, v, (v == 45), (v <= 46), hand, hd, hf);
        end
        a_wr = 1'b0; a_sof = 1'b0;
        drain();

        // Reset mid-frame while a window is being presented.
        for (int v = 1; v <= 13; v++)
            send(0, v, (v == 1), (v != 13), 1'b0, 200'd0, 4'd0);
        a_wr = 1'b0; a_sof = 1'b0;
        chk("pre_reset_wen", 13, {199'd0, a_wen}, 200'd1);
        #1 rst_a = 1'b1;
        #1;
        chk("async_reset_a", 13, {124'd0, a_data, a_wen, a_sofo, a_eol, a_eof}, 200'd0);
        chk("async_reset_border_a", 13, {199'd0, a_border}, 200'd0);
        mr[0] = 0; mc[0] = 0;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        for (int v = 1; v <= 20; v++) begin
            hd = '0;
            hd[71:0] = {8'd1, 64'd0};
            send(0, v, 1'b0, 1'b1, (v == 1), hd, 4'b1001);
        end
        a_wr = 1'b0;
        drain();

        // 5x5: one full frame back-to-back.
        for (int v = 1; v <= 64; v++) begin
            hand = 1'b1;
            case (v)
                29: begin
                    hd = {8'd29, 8'd28, 8'd27, 8'd26, 8'd25, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17,
                          8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 40'd0};
                    hf = 4'b0001;
                end
                37: begin
                    hd = {8'd37, 8'd36, 8'd35, 8'd34, 8'd33, 8'd29, 8'd28, 8'd27, 8'd26, 8'd25,
                          8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,
                          8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
                    hf = 4'b0000;
                end
                default: begin hand = 1'b0; hd = '0; hf = 4'b0000; end
            endcase
            send(1, v, 1'b0, 1'b0, hand, hd, hf);
        end
        b_wr = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
